// File: rtl/spi_master_link.sv
// spi_master_link
//   Byte-oriented SPI master. Bytes arrive on a valid/ready stream and are
//   shifted out MSB-first on spi_mosi. The byte clocked in on spi_miso at the
//   same time is returned on rx_data with a one-cycle rx_valid strobe. spi_ss
//   stays low across a multi-byte transaction until a byte tagged tx_last has
//   finished, followed by an SS hold time and a minimum SS idle gap.
//
// Parameters
//   CLK_DIV   SCK half-period in clk cycles (1..255). Also sets the SS hold
//             time after the last byte and the SS idle gap before the next
//             transaction.
//
// Build option
//   SPI_MODE3_EN  defined   : CPOL=1/CPHA=1. SCK idles high. It falls at the
//                             accept edge and rises to sample mid-bit.
//                 undefined : mode 0. SCK idles low.
//   Both modes sample MISO on the rising SCK edge, update MOSI on the falling
//   edge (or at accept), and have identical byte timing.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_valid  in   tx_data/tx_last valid
//   tx_ready  out  byte accepted on this cycle's clk edge when tx_valid is high
//   tx_data   in   byte to transmit
//   tx_last   in   release SS after this byte
//   rx_valid  out  one-cycle strobe, rx_data valid
//   rx_data   out  byte captured from MISO
//   busy      out  high whenever the FSM is not idle
//   spi_ss    out  active-low slave select
//   spi_sck   out  serial clock
//   spi_mosi  out  master out
//   spi_miso  in   master in
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | SS high, ready for the first byte of a transaction
// SHIFT_LO | SCK low half of a bit (CLK_DIV cycles); samples MISO at exit
// SHIFT_HI | SCK high half of a bit (CLK_DIV cycles); advances MOSI at exit
// WAIT     | between bytes of a transaction, SS low, ready for next byte
// HOLD     | SS hold after the last byte (CLK_DIV cycles)
// GAP      | minimum SS deassert time (CLK_DIV cycles), not ready

module spi_master_link #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_ss,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

`ifdef SPI_MODE3_EN
    localparam logic SCK_IDLE = 1'b1;
`else
    localparam logic SCK_IDLE = 1'b0;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  div_cnt, div_cnt_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    // Only bits 6..0 of the byte are kept; bit 7 goes straight to MOSI at accept.
    logic [6:0]  tx_sh, tx_sh_nx;
    logic [7:0]  rx_sh, rx_sh_nx;
    logic        last_q, last_nx;
    logic        ss_nx, sck_nx, mosi_nx;
    logic        rx_valid_nx;
    logic [7:0]  rx_data_nx;
    logic        div_end;
    logic        accept;

    // Gated with rst_n so tx_ready stays low while reset is asserted.
    assign tx_ready = rst_n && ((state == S_IDLE) || (state == S_WAIT));
    assign busy     = (state != S_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign div_end  = (div_cnt == DIV_LAST);

    always_comb begin
        state_nx    = state;
        div_cnt_nx  = div_cnt;
        bit_cnt_nx  = bit_cnt;
        tx_sh_nx    = tx_sh;
        rx_sh_nx    = rx_sh;
        last_nx     = last_q;
        ss_nx       = spi_ss;
        sck_nx      = spi_sck;
        mosi_nx     = spi_mosi;
        rx_valid_nx = 1'b0;
        rx_data_nx  = rx_data;

        unique case (state)
            S_IDLE, S_WAIT: begin
                if (state == S_IDLE) begin
                    ss_nx = 1'b1;
                end
                if (accept) begin
                    ss_nx      = 1'b0;
                    // In mode 3 this is the first falling SCK edge; in mode 0
                    // SCK is already low.
                    sck_nx     = 1'b0;
                    mosi_nx    = tx_data[7];
                    tx_sh_nx   = tx_data[6:0];
                    last_nx    = tx_last;
                    bit_cnt_nx = 3'd0;
                    div_cnt_nx = 8'd0;
                    state_nx   = S_SHIFT_LO;
                end
            end

            S_SHIFT_LO: begin
                if (div_end) begin
                    div_cnt_nx = 8'd0;
                    sck_nx     = 1'b1;
                    rx_sh_nx   = {rx_sh[6:0], spi_miso};
                    state_nx   = S_SHIFT_HI;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end

            S_SHIFT_HI: begin
                if (div_end) begin
                    div_cnt_nx = 8'd0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        sck_nx     = 1'b0;
                        mosi_nx    = tx_sh[6];
                        tx_sh_nx   = {tx_sh[5:0], 1'b0};
                        state_nx   = S_SHIFT_LO;
                    end else begin
                        // Last bit done: return SCK to its idle level.
                        sck_nx      = SCK_IDLE;
                        rx_data_nx  = rx_sh;
                        rx_valid_nx = 1'b1;
                        state_nx    = last_q ? S_HOLD : S_WAIT;
                    end
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end

            S_HOLD: begin
                if (div_end) begin
                    div_cnt_nx = 8'd0;
                    ss_nx      = 1'b1;
                    state_nx   = S_GAP;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end

            S_GAP: begin
                if (div_end) begin
                    div_cnt_nx = 8'd0;
                    state_nx   = S_IDLE;
                end else begin
                    div_cnt_nx = div_cnt + 8'd1;
                end
            end

            default: begin
                state_nx   = S_IDLE;
                div_cnt_nx = 8'd0;
                ss_nx      = 1'b1;
                sck_nx     = SCK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 7'd0;
            rx_sh    <= 8'd0;
            last_q   <= 1'b0;
            spi_ss   <= 1'b1;
            spi_sck  <= SCK_IDLE;
            spi_mosi <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'd0;
        end else begin
            state    <= state_nx;
            div_cnt  <= div_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            tx_sh    <= tx_sh_nx;
            rx_sh    <= rx_sh_nx;
            last_q   <= last_nx;
            spi_ss   <= ss_nx;
            spi_sck  <= sck_nx;
            spi_mosi <= mosi_nx;
            rx_valid <= rx_valid_nx;
            rx_data  <= rx_data_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_link.sv
// Testbench for spi_master_link. Instance A runs CLK_DIV=2 against a model
// slave that returns a chosen byte MSB-first. Instance B runs CLK_DIV=1 with
// MOSI looped back to MISO. SCK idle level follows SPI_MODE3_EN.

module tb_spi_master_link;

`ifdef SPI_MODE3_EN
    localparam logic SCK_IDLE = 1'b1;
`else
    localparam logic SCK_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_tx_valid, a_tx_ready, a_tx_last, a_rx_valid, a_busy;
    logic [7:0] a_tx_data, a_rx_data;
    logic       a_ss, a_sck, a_mosi, a_miso;

    logic       b_tx_valid, b_tx_ready, b_tx_last, b_rx_valid, b_busy;
    logic [7:0] b_tx_data, b_rx_data;
    logic       b_ss, b_sck, b_mosi, b_miso;

    int checks = 0;
    int errors = 0;

    spi_master_link #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data), .tx_last(a_tx_last),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy),
        .spi_ss(a_ss), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso)
    );

    spi_master_link #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data), .tx_last(b_tx_last),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy),
        .spi_ss(b_ss), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso)
    );

    assign b_miso = b_mosi;

    // SCK rising-edge monitor for A: counts edges and records MOSI as the slave sees it.
    int         a_rises = 0;
    logic [7:0] a_mosi_cap = 8'h00;
    always @(posedge a_sck) begin
        a_rises    <= a_rises + 1;
        a_mosi_cap <= {a_mosi_cap[6:0], a_mosi};
    end

    // Model slave: presents bit 7-k of a_miso_byte after k rising edges of this byte.
    logic [7:0] a_miso_byte = 8'h00;
    int         a_base = 0;
    int         a_k;
    assign a_k    = a_rises - a_base;
    assign a_miso = (a_k >= 0 && a_k < 8) ? a_miso_byte[3'(7 - a_k)] : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic [7:0] d, input logic last, input logic [7:0] mb);
        a_tx_data   = d;
        a_tx_last   = last;
        a_miso_byte = mb;
        a_base      = a_rises;
        a_tx_valid  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_tx_valid = 1'b0; a_tx_data = 8'h00; a_tx_last = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = 8'h00; b_tx_last = 1'b0;
        #23;
        checks++;
        if ({a_ss, a_sck, a_mosi, a_rx_valid, a_busy, a_tx_ready} !== {1'b1, SCK_IDLE, 4'b0000}) begin
            errors++;
            $display("FAIL reset_a_outputs: got ss,sck,mosi,rxv,busy,rdy=%b required %b",
                     {a_ss, a_sck, a_mosi, a_rx_valid, a_busy, a_tx_ready}, {1'b1, SCK_IDLE, 4'b0000});
        end
        checks++;
        if (a_rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_a_rx_data: got %h required 00", a_rx_data);
        end
        checks++;
        if ({b_ss, b_sck, b_mosi, b_rx_valid, b_busy, b_tx_ready} !== {1'b1, SCK_IDLE, 4'b0000}) begin
            errors++;
            $display("FAIL reset_b_outputs: got %b required %b",
                     {b_ss, b_sck, b_mosi, b_rx_valid, b_busy, b_tx_ready}, {1'b1, SCK_IDLE, 4'b0000});
        end
        checks++;
        if (b_rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_b_rx_data: got %h required 00", b_rx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({a_tx_ready, b_tx_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_release_ready: got %b required 11", {a_tx_ready, b_tx_ready});
        end
    endtask

    // Scenario 1: 0xA5, last, slave returns 0x3C.
    task automatic test_single();
        int rx_cyc = -1, rx_cnt = 0, ss_cyc = -1, rdy_cyc = -1, rises0, rises = 0;
        logic [7:0] rxd = 8'h00, mcap = 8'h00;
        rises0 = a_rises;
        a_drive(8'hA5, 1'b1, 8'h3C);
        checks++;
        if (a_tx_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready_idle: got %b required 1", a_tx_ready);
        end
        tick();
        a_tx_valid = 1'b0;
        checks++;
        if ({a_ss, a_busy, a_tx_ready} !== 3'b010) begin
            errors++; $display("FAIL single_after_accept: got ss,busy,rdy=%b required 010", {a_ss, a_busy, a_tx_ready});
        end
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (a_rx_valid) begin
                rx_cnt++;
                if (rx_cyc < 0) rx_cyc = c;
                rxd   = a_rx_data;
                mcap  = a_mosi_cap;
                rises = a_rises - rises0;
            end
            if (a_ss && ss_cyc < 0) ss_cyc = c;
            if (a_tx_ready && rdy_cyc < 0) rdy_cyc = c;
        end
        checks++;
        if (rx_cnt !== 1) begin errors++; $display("FAIL single_rx_count: got %0d required 1", rx_cnt); end
        checks++;
        if (rx_cyc !== 32) begin errors++; $display("FAIL single_rx_latency: got %0d required 32", rx_cyc); end
        checks++;
        if (rxd !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h required 3c", rxd); end
        checks++;
        if (mcap !== 8'hA5) begin errors++; $display("FAIL single_mosi_bits: got %h required a5", mcap); end
        checks++;
        if (rises !== 8) begin errors++; $display("FAIL single_sck_rises: got %0d required 8", rises); end
        checks++;
        if (ss_cyc !== 34) begin errors++; $display("FAIL single_ss_low_len: got %0d required 34", ss_cyc); end
        checks++;
        if (rdy_cyc !== 36) begin errors++; $display("FAIL single_gap_ready: got %0d required 36", rdy_cyc); end
        checks++;
        if ({a_busy, a_sck, a_ss} !== {1'b0, SCK_IDLE, 1'b1}) begin
            errors++; $display("FAIL single_end_idle: got busy,sck,ss=%b required %b", {a_busy, a_sck, a_ss}, {1'b0, SCK_IDLE, 1'b1});
        end
    endtask

    // Scenario 2: 0x01,0x02,0x03 burst, next byte offered while rx_valid is high.
    // Each accept lands on the edge closing the rx_valid cycle, so strobes are
    // 32 cycles of shifting plus that one cycle apart.
    task automatic test_burst();
        logic [7:0] tx_b [3];
        int         exp_rx [3];
        int         rx_at [3];
        logic [7:0] rxd [3];
        logic [7:0] mc [3];
        int n = 0, ss_high = 0, rises0;
        logic pend = 1'b0;
        tx_b[0] = 8'h01; tx_b[1] = 8'h02; tx_b[2] = 8'h03;
        exp_rx[0] = 32; exp_rx[1] = 65; exp_rx[2] = 98;
        for (int i = 0; i < 3; i++) begin rx_at[i] = -1; rxd[i] = 8'h00; mc[i] = 8'h00; end
        rises0 = a_rises;
        a_drive(tx_b[0], 1'b0, 8'h96);
        tick();
        a_tx_valid = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (pend) begin a_tx_valid = 1'b0; pend = 1'b0; end
            if (n < 3 && a_ss) ss_high++;
            if (a_rx_valid && n < 3) begin
                rx_at[n] = c; rxd[n] = a_rx_data; mc[n] = a_mosi_cap;
                n++;
                if (n < 3) begin
                    a_drive(tx_b[n], (n == 2), 8'h96);
                    pend = 1'b1;
                end
            end
        end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL burst_rx_count: got %0d required 3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_at[i] !== exp_rx[i]) begin
                errors++; $display("FAIL burst_rx_time[%0d]: got %0d required %0d", i, rx_at[i], exp_rx[i]);
            end
            checks++;
            if (rxd[i] !== 8'h96) begin
                errors++; $display("FAIL burst_rx_data[%0d]: got %h required 96", i, rxd[i]);
            end
            checks++;
            if (mc[i] !== tx_b[i]) begin
                errors++; $display("FAIL burst_mosi[%0d]: got %h required %h", i, mc[i], tx_b[i]);
            end
        end
        checks++;
        if (ss_high !== 0) begin errors++; $display("FAIL burst_ss_continuous: got %0d high samples required 0", ss_high); end
        checks++;
        if (a_rises - rises0 !== 24) begin
            errors++; $display("FAIL burst_sck_rises: got %0d required 24", a_rises - rises0);
        end
    endtask

    // Scenario 3: 0x55 not last, 50 idle cycles in WAIT, then 0xFF last.
    task automatic test_wait();
        int rx_cyc = -1, ss_cyc = -1, bad = 0;
        logic [7:0] rxd = 8'h00, mcap = 8'h00;
        a_drive(8'h55, 1'b0, 8'hAA);
        tick();
        a_tx_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (a_rx_valid && rx_cyc < 0) begin rx_cyc = c; rxd = a_rx_data; mcap = a_mosi_cap; end
            if (rx_cyc >= 0) break;
        end
        checks++;
        if (rx_cyc !== 32) begin errors++; $display("FAIL wait_first_rx_time: got %0d required 32", rx_cyc); end
        checks++;
        if ({rxd, mcap} !== {8'hAA, 8'h55}) begin
            errors++; $display("FAIL wait_first_byte: got rx %h mosi %h required rx aa mosi 55", rxd, mcap);
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            if (a_ss !== 1'b0 || a_sck !== SCK_IDLE || a_tx_ready !== 1'b1 || a_rx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wait_hold_state: got %0d bad cycles required 0", bad); end
        rx_cyc = -1;
        a_drive(8'hFF, 1'b1, 8'h0F);
        tick();
        a_tx_valid = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (a_rx_valid && rx_cyc < 0) begin rx_cyc = c; rxd = a_rx_data; mcap = a_mosi_cap; end
            if (a_ss && ss_cyc < 0) ss_cyc = c;
        end
        checks++;
        if (rx_cyc !== 32) begin errors++; $display("FAIL wait_second_rx_time: got %0d required 32", rx_cyc); end
        checks++;
        if ({rxd, mcap} !== {8'h0F, 8'hFF}) begin
            errors++; $display("FAIL wait_second_byte: got rx %h mosi %h required rx 0f mosi ff", rxd, mcap);
        end
        checks++;
        if (ss_cyc !== 34) begin errors++; $display("FAIL wait_ss_release: got %0d required 34", ss_cyc); end
    endtask

    // Scenario 4: reset asserted during bit 4 of 0xFF, then a fresh 0x81.
    task automatic test_reset_mid();
        int rx_cnt = 0, rx_cyc = -1;
        logic [7:0] rxd = 8'h00, mcap = 8'h00;
        a_drive(8'hFF, 1'b1, 8'h5A);
        tick();
        a_tx_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (a_rx_valid) rx_cnt++;
        end
        checks++;
        if ({a_ss, a_mosi, a_busy} !== 3'b011) begin
            errors++; $display("FAIL rstmid_pre_state: got ss,mosi,busy=%b required 011", {a_ss, a_mosi, a_busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ss, a_sck, a_mosi, a_busy, a_tx_ready, a_rx_valid} !== {1'b1, SCK_IDLE, 4'b0000}) begin
            errors++;
            $display("FAIL rstmid_abort: got ss,sck,mosi,busy,rdy,rxv=%b required %b",
                     {a_ss, a_sck, a_mosi, a_busy, a_tx_ready, a_rx_valid}, {1'b1, SCK_IDLE, 4'b0000});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (a_rx_valid) rx_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (rx_cnt !== 0) begin errors++; $display("FAIL rstmid_no_rx: got %0d strobes required 0", rx_cnt); end
        checks++;
        if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", a_tx_ready); end
        a_drive(8'h81, 1'b1, 8'h7E);
        tick();
        a_tx_valid = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (a_rx_valid) begin
                rx_cnt++;
                if (rx_cyc < 0) rx_cyc = c;
                rxd = a_rx_data; mcap = a_mosi_cap;
            end
        end
        checks++;
        if ({rx_cnt, rx_cyc} !== {32'd1, 32'd32}) begin
            errors++; $display("FAIL rstmid_fresh_timing: got count %0d at %0d required count 1 at 32", rx_cnt, rx_cyc);
        end
        checks++;
        if ({rxd, mcap} !== {8'h7E, 8'h81}) begin
            errors++; $display("FAIL rstmid_fresh_byte: got rx %h mosi %h required rx 7e mosi 81", rxd, mcap);
        end
    endtask

    // Scenario 5: CLK_DIV=1, 0xC3 looped back.
    task automatic test_div1();
        int rx_cyc = -1, ss_cyc = -1, toggle_bad = 0;
        logic [7:0] rxd = 8'h00;
        logic prev;
        checks++;
        if (b_tx_ready !== 1'b1) begin errors++; $display("FAIL div1_ready: got %b required 1", b_tx_ready); end
        b_tx_data = 8'hC3; b_tx_last = 1'b1; b_tx_valid = 1'b1;
        tick();
        b_tx_valid = 1'b0;
        checks++;
        if ({b_sck, b_ss} !== 2'b00) begin
            errors++; $display("FAIL div1_accept_state: got sck,ss=%b required 00", {b_sck, b_ss});
        end
        prev = b_sck;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c <= 15 && b_sck === prev) toggle_bad++;
            prev = b_sck;
            if (b_rx_valid && rx_cyc < 0) begin rx_cyc = c; rxd = b_rx_data; end
            if (b_ss && ss_cyc < 0) ss_cyc = c;
        end
        checks++;
        if (toggle_bad !== 0) begin errors++; $display("FAIL div1_sck_toggle: got %0d stuck cycles required 0", toggle_bad); end
        checks++;
        if (rx_cyc !== 16) begin errors++; $display("FAIL div1_rx_time: got %0d required 16", rx_cyc); end
        checks++;
        if (rxd !== 8'hC3) begin errors++; $display("FAIL div1_loopback: got %h required c3", rxd); end
        checks++;
        if (ss_cyc !== 17) begin errors++; $display("FAIL div1_ss_release: got %0d required 17", ss_cyc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wait();
        test_reset_mid();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
